// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad number-entry block.
// Imported by keypad_key_encoder and keypad_number_entry.
package keypad_pkg;

    typedef logic [3:0] Digit;

    localparam int unsigned DIGIT_BASE = 10;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        IDLE         = 2'd1,
        HELD         = 2'd2
    } state_t;

endpackage

// File: rtl/keypad_key_encoder.sv
// Combinational encoder: one-hot digit keys -> digit index, exactly-one flag and any-key flag.
module keypad_key_encoder
    import keypad_pkg::*;
(
    input  logic [9:0] i_key,
    output Digit       o_digit,
    output logic       o_exactly_one,
    output logic       o_any
);

    logic [9:0] w_key_minus_one;

    assign w_key_minus_one = i_key - 10'd1;
    assign o_any           = |i_key;
    // Power-of-two test: a single set bit leaves nothing after clearing the lowest one.
    assign o_exactly_one   = o_any && ((i_key & w_key_minus_one) == 10'd0);

    always_comb begin
        o_digit = '0;
        for (int i = 9; i >= 0; i--) begin
            if (i_key[i]) begin
                o_digit = Digit'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_number_entry.sv
// Edge-accepted keypad number entry with backspace, clear, enter/commit and overflow guard.
// Optional idle auto-clear enabled by defining KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int MAX_DIGITS     = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       key,
    input  logic             backspace,
    input  logic             clear,
    input  logic             enter,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       digit_count,
    output logic [WIDTH-1:0] committed,
    output logic             commit_valid,
    output logic [3:0]       last_digit,
    output logic             overflow
);

    if (MAX_DIGITS < 1 || MAX_DIGITS > 10 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("keypad_number_entry: MAX_DIGITS must be 1..10 and TIMEOUT_CYCLES >= 1");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [3:0]       r_digit_count;
    logic [WIDTH-1:0] r_committed;
    logic             r_commit_valid;
    Digit             r_last_digit;
    logic             r_overflow;

    Digit             w_digit;
    logic             w_exactly_one;
    logic             w_any_key;
    logic             w_any;
    logic [WIDTH+3:0] w_next_value;
    logic             w_reject;

    keypad_key_encoder u_encoder (
        .i_key         (key),
        .o_digit       (w_digit),
        .o_exactly_one (w_exactly_one),
        .o_any         (w_any_key)
    );

    assign w_any = backspace | clear | enter | w_any_key;

    // Four extra bits hold value*10+9 without wrapping, so the range check is exact.
    assign w_next_value = ({4'b0000, r_value} * (WIDTH+4)'(DIGIT_BASE)) + (WIDTH+4)'(w_digit);
    assign w_reject     = (r_digit_count == 4'(MAX_DIGITS)) || (|w_next_value[WIDTH+3:WIDTH]);

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_idle_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT_RELEASE;
            r_value        <= '0;
            r_digit_count  <= '0;
            r_committed    <= '0;
            r_commit_valid <= 1'b0;
            r_last_digit   <= '0;
            r_overflow     <= 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
            r_idle_cnt     <= '0;
`endif
        end else begin
            r_commit_valid <= 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
            r_idle_cnt     <= '0;
`endif
            case (r_state)
                WAIT_RELEASE: begin
                    if (!w_any) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_any) begin
                        r_state <= HELD;
                        if (clear) begin
                            r_value       <= '0;
                            r_digit_count <= '0;
                            r_last_digit  <= '0;
                            r_overflow    <= 1'b0;
                        end else if (enter) begin
                            r_committed    <= r_value;
                            r_commit_valid <= 1'b1;
                            r_value        <= '0;
                            r_digit_count  <= '0;
                            r_overflow     <= 1'b0;
                        end else if (backspace) begin
                            r_overflow <= 1'b0;
                            if (r_digit_count != 4'd0) begin
                                r_value       <= WIDTH'(r_value / WIDTH'(DIGIT_BASE));
                                r_digit_count <= r_digit_count - 4'd1;
                            end
                        end else if (w_exactly_one) begin
                            if (w_reject) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_value       <= w_next_value[WIDTH-1:0];
                                r_digit_count <= r_digit_count + 4'd1;
                                r_last_digit  <= w_digit;
                            end
                        end
                    end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
                    else if (r_digit_count != 4'd0) begin
                        if (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_value       <= '0;
                            r_digit_count <= '0;
                            r_last_digit  <= '0;
                            r_overflow    <= 1'b0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                HELD: begin
                    if (!w_any) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= WAIT_RELEASE;
            endcase
        end
    end

    assign value        = r_value;
    assign digit_count  = r_digit_count;
    assign committed    = r_committed;
    assign commit_valid = r_commit_valid;
    assign last_digit   = r_last_digit;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry: entry, hold, overflow, backspace, conflicts, reset.
// Timeout scenario runs when KEYPAD_ENTRY_TIMEOUT_EN is defined.
module tb_keypad_number_entry;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [9:0]       key;
    logic             backspace;
    logic             clear;
    logic             enter;
    logic [WIDTH-1:0] value;
    logic [3:0]       digit_count;
    logic [WIDTH-1:0] committed;
    logic             commit_valid;
    logic [3:0]       last_digit;
    logic             overflow;

    int n_total;
    int n_bad;

    keypad_number_entry #(
        .WIDTH          (WIDTH),
        .MAX_DIGITS     (5),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .backspace    (backspace),
        .clear        (clear),
        .enter        (enter),
        .value        (value),
        .digit_count  (digit_count),
        .committed    (committed),
        .commit_valid (commit_valid),
        .last_digit   (last_digit),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input int d);
        key = 10'(1 << d);
        tick();
        key = '0;
        tick();
    endtask

    task automatic press_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic press_backspace();
        backspace = 1'b1;
        tick();
        backspace = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key = '0; backspace = 0; clear = 0; enter = 0;
        repeat (3) tick();
        n_total += 6;
        if (value !== 16'd0)       begin n_bad++; $display("FAIL reset_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0)  begin n_bad++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
        if (committed !== 16'd0)   begin n_bad++; $display("FAIL reset_committed got=%0d exp=0", committed); end
        if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cv got=%0b exp=0", commit_valid); end
        if (last_digit !== 4'd0)   begin n_bad++; $display("FAIL reset_last got=%0d exp=0", last_digit); end
        if (overflow !== 1'b0)     begin n_bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_entry();
        press_digit(1); press_digit(2); press_digit(3);
        n_total += 3;
        if (value !== 16'd123)    begin n_bad++; $display("FAIL entry_value got=%0d exp=123", value); end
        if (digit_count !== 4'd3) begin n_bad++; $display("FAIL entry_count got=%0d exp=3", digit_count); end
        if (last_digit !== 4'd3)  begin n_bad++; $display("FAIL entry_last got=%0d exp=3", last_digit); end
        enter = 1'b1;
        tick();
        n_total += 4;
        if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL enter_cv got=%0b exp=1", commit_valid); end
        if (committed !== 16'd123) begin n_bad++; $display("FAIL enter_committed got=%0d exp=123", committed); end
        if (value !== 16'd0)       begin n_bad++; $display("FAIL enter_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0)  begin n_bad++; $display("FAIL enter_count got=%0d exp=0", digit_count); end
        tick();
        n_total++;
        if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL enter_pulse_width got=%0b exp=0", commit_valid); end
        enter = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int pulses;
        pulses = 0;
        key = 10'(1 << 5);
        repeat (20) begin
            tick();
            if (commit_valid) pulses++;
        end
        key = '0;
        tick();
        n_total += 3;
        if (value !== 16'd5)      begin n_bad++; $display("FAIL hold_value got=%0d exp=5", value); end
        if (digit_count !== 4'd1) begin n_bad++; $display("FAIL hold_count got=%0d exp=1", digit_count); end
        if (pulses != 0)          begin n_bad++; $display("FAIL hold_commit got=%0d exp=0", pulses); end
        press_clear();
    endtask

    task automatic test_overflow();
        press_digit(6); press_digit(5); press_digit(5); press_digit(3); press_digit(5);
        n_total += 3;
        if (value !== 16'd65535)  begin n_bad++; $display("FAIL max_value got=%0d exp=65535", value); end
        if (digit_count !== 4'd5) begin n_bad++; $display("FAIL max_count got=%0d exp=5", digit_count); end
        if (overflow !== 1'b0)    begin n_bad++; $display("FAIL max_ovf got=%0b exp=0", overflow); end
        press_clear();
        press_digit(6); press_digit(5); press_digit(5); press_digit(3); press_digit(6);
        n_total += 4;
        if (value !== 16'd6553)   begin n_bad++; $display("FAIL range_value got=%0d exp=6553", value); end
        if (digit_count !== 4'd4) begin n_bad++; $display("FAIL range_count got=%0d exp=4", digit_count); end
        if (overflow !== 1'b1)    begin n_bad++; $display("FAIL range_ovf got=%0b exp=1", overflow); end
        if (last_digit !== 4'd3)  begin n_bad++; $display("FAIL range_last got=%0d exp=3", last_digit); end
        press_clear();
        n_total++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL clear_ovf got=%0b exp=0", overflow); end
        press_digit(1); press_digit(2); press_digit(3); press_digit(4); press_digit(5); press_digit(0);
        n_total += 2;
        if (value !== 16'd12345) begin n_bad++; $display("FAIL maxdig_value got=%0d exp=12345", value); end
        if (overflow !== 1'b1)   begin n_bad++; $display("FAIL maxdig_ovf got=%0b exp=1", overflow); end
        press_backspace();
        n_total += 3;
        if (value !== 16'd1234)   begin n_bad++; $display("FAIL bs_ovf_value got=%0d exp=1234", value); end
        if (digit_count !== 4'd4) begin n_bad++; $display("FAIL bs_ovf_count got=%0d exp=4", digit_count); end
        if (overflow !== 1'b0)    begin n_bad++; $display("FAIL bs_ovf_flag got=%0b exp=0", overflow); end
        press_clear();
    endtask

    task automatic test_backspace();
        press_digit(4); press_digit(2); press_backspace();
        n_total += 2;
        if (value !== 16'd4)      begin n_bad++; $display("FAIL bs1_value got=%0d exp=4", value); end
        if (digit_count !== 4'd1) begin n_bad++; $display("FAIL bs1_count got=%0d exp=1", digit_count); end
        press_backspace(); press_backspace();
        n_total += 2;
        if (value !== 16'd0)      begin n_bad++; $display("FAIL bs3_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0) begin n_bad++; $display("FAIL bs3_count got=%0d exp=0", digit_count); end
        press_digit(0); press_digit(7);
        n_total += 3;
        if (value !== 16'd7)      begin n_bad++; $display("FAIL lead0_value got=%0d exp=7", value); end
        if (digit_count !== 4'd2) begin n_bad++; $display("FAIL lead0_count got=%0d exp=2", digit_count); end
        if (last_digit !== 4'd7)  begin n_bad++; $display("FAIL lead0_last got=%0d exp=7", last_digit); end
        press_clear();
    endtask

    task automatic test_conflicts();
        int pulses;
        press_digit(9);
        key = 10'b00_1000_1000;
        tick();
        key = '0;
        tick();
        n_total += 2;
        if (value !== 16'd9)      begin n_bad++; $display("FAIL multikey_value got=%0d exp=9", value); end
        if (digit_count !== 4'd1) begin n_bad++; $display("FAIL multikey_count got=%0d exp=1", digit_count); end
        pulses = 0;
        clear = 1'b1; enter = 1'b1;
        tick();
        if (commit_valid) pulses++;
        clear = 1'b0; enter = 1'b0;
        tick();
        if (commit_valid) pulses++;
        n_total += 3;
        if (value !== 16'd0)       begin n_bad++; $display("FAIL clr_ent_value got=%0d exp=0", value); end
        if (pulses != 0)           begin n_bad++; $display("FAIL clr_ent_commit got=%0d exp=0", pulses); end
        if (committed !== 16'd123) begin n_bad++; $display("FAIL clr_ent_committed got=%0d exp=123", committed); end
        enter = 1'b1;
        tick();
        n_total += 2;
        if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL empty_enter_cv got=%0b exp=1", commit_valid); end
        if (committed !== 16'd0)   begin n_bad++; $display("FAIL empty_enter_val got=%0d exp=0", committed); end
        enter = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_entry();
        press_digit(1); press_digit(2);
        key = 10'(1 << 8);
        tick();
        n_total++;
        if (value !== 16'd128) begin n_bad++; $display("FAIL pre_reset_value got=%0d exp=128", value); end
        rst_n = 1'b0;
        #1;
        n_total += 3;
        if (value !== 16'd0)      begin n_bad++; $display("FAIL mid_reset_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0) begin n_bad++; $display("FAIL mid_reset_count got=%0d exp=0", digit_count); end
        if (last_digit !== 4'd0)  begin n_bad++; $display("FAIL mid_reset_last got=%0d exp=0", last_digit); end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_total += 2;
        if (value !== 16'd0)      begin n_bad++; $display("FAIL held_through_reset_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0) begin n_bad++; $display("FAIL held_through_reset_count got=%0d exp=0", digit_count); end
        key = '0;
        tick();
        press_digit(8);
        n_total += 2;
        if (value !== 16'd8)      begin n_bad++; $display("FAIL repress_value got=%0d exp=8", value); end
        if (digit_count !== 4'd1) begin n_bad++; $display("FAIL repress_count got=%0d exp=1", digit_count); end
        press_clear();
    endtask

    task automatic test_timeout();
        int pulses;
        press_digit(9);
        pulses = 0;
        repeat (5) tick();
        n_total++;
        if (value !== 16'd9) begin n_bad++; $display("FAIL idle_early_value got=%0d exp=9", value); end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        for (int i = 0; i < 20 && value != 16'd0; i++) begin
            tick();
            if (commit_valid) pulses++;
        end
        n_total += 3;
        if (value !== 16'd0)      begin n_bad++; $display("FAIL timeout_value got=%0d exp=0", value); end
        if (digit_count !== 4'd0) begin n_bad++; $display("FAIL timeout_count got=%0d exp=0", digit_count); end
        if (pulses != 0)          begin n_bad++; $display("FAIL timeout_commit got=%0d exp=0", pulses); end
`else
        repeat (30) begin
            tick();
            if (commit_valid) pulses++;
        end
        n_total += 2;
        if (value !== 16'd9) begin n_bad++; $display("FAIL persist_value got=%0d exp=9", value); end
        if (pulses != 0)     begin n_bad++; $display("FAIL persist_commit got=%0d exp=0", pulses); end
        press_clear();
`endif
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_basic_entry();
        test_hold();
        test_overflow();
        test_backspace();
        test_conflicts();
        test_reset_mid_entry();
        test_timeout();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_number_entry.md
Name: keypad_number_entry

Overview:
- Sequential, parametrised successor to the combinational digit-append selector: builds an unsigned decimal number from keypad presses over time.
- Provides edge-detected key acceptance, backspace, clear, enter/commit and overflow protection.
- Sits between the keypad button inputs and the seven-segment/number consumers.

Parameters:
WIDTH, 16, bit width of accumulated and committed value
MAX_DIGITS, 5, maximum digits accepted per entry (1..10)
TIMEOUT_CYCLES, 1000, idle cycles before auto-clear (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
key  input  10  key[d] high while digit key d (0..9) is held
backspace  input  1  level, held button
clear  input  1  level, held button
enter  input  1  level, held button
value  output  WIDTH  current accumulated (uncommitted) number
digit_count  output  4  digits currently in value
committed  output  WIDTH  last committed number
commit_valid  output  1  one-cycle pulse when committed updates
last_digit  output  4  most recently accepted digit (0 if none)
overflow  output  1  sticky: last digit press was rejected

Behaviour:
- Reset (async assert, sync release): value=0, digit_count=0, committed=0, commit_valid=0, last_digit=0, overflow=0, FSM=WAIT_RELEASE.
- Any control = backspace|clear|enter|(|key). A press is accepted only on the cycle any-control rises from all-released. Holding never repeats.
- FSM states:
  - WAIT_RELEASE: stay until all inputs are low -> IDLE.
  - IDLE: on first cycle any input is high, sample and act (below) -> HELD.
  - HELD: all inputs low -> IDLE.
- Action priority on the accepting cycle, highest first: clear > enter > backspace > digit.
- clear: value=0, digit_count=0, last_digit=0, overflow=0.
- enter: committed<=value, commit_valid=1 for exactly that cycle, then value=0, digit_count=0, overflow=0. Enter with digit_count=0 still commits 0.
- backspace: if digit_count>0, value<=value/10 and digit_count-1; else no-op. Clears overflow.
- digit: requires exactly one key bit set; more than one key bit set -> ignored, FSM still goes to HELD.
  - Let d = the key index; compute value*10+d at WIDTH+4 bits.
  - Reject if digit_count==MAX_DIGITS or result > 2^WIDTH-1: value unchanged, overflow=1.
  - Otherwise value<=result, digit_count+1, last_digit<=d.
- Leading zeros count as digits: 0 then 7 gives value=7, digit_count=2.
- Latency: every update is visible one cycle after the accepting edge; commit_valid is registered.
- Reset mid-entry discards everything; the FSM restarts in WAIT_RELEASE, so buttons held through reset are not accepted.

Optional Feature:
- Macro KEYPAD_ENTRY_TIMEOUT_EN.
- Defined: a counter runs while digit_count>0 and FSM is IDLE. It resets on any accepted action. On reaching TIMEOUT_CYCLES it performs a clear action with no commit.
- Undefined: no counter and no timeout; value persists indefinitely.

Decomposition:
- Package keypad_pkg: typedef Digit (4-bit), DIGIT_BASE=10 constant, FSM state enum (WAIT_RELEASE, IDLE, HELD).
- Sub-module keypad_key_encoder (combinational): key[9:0] -> digit, exactly_one, any.

Test Plan:
- Press 1, 2, 3 separately, then enter -> committed=123, one commit_valid pulse, value=0, digit_count=0.
- Hold key 5 for 20 cycles -> value=5 only, digit_count=1.
- WIDTH=16: enter 6,5,5,3,5 -> value=65535. Then enter 6,5,5,3,6 -> value=6553, overflow=1.
- Enter 4,2 then backspace -> value=4, digit_count=1. Backspace twice more -> value=0, digit_count=0 (no-op on empty).
- Keys 3 and 7 together -> ignored. clear and enter together with value=9 -> value=0, no commit_valid.
- rst_n low mid-entry with key 8 held -> all outputs 0; no digit accepted until key 8 is released and pressed again. With the macro defined, TIMEOUT_CYCLES=10: press 9 and wait 10 idle cycles -> value=0, no commit.
